// File: rtl/imem_loader.sv
// Instruction-store writer: a 16 x 8 program memory filled from a framed
// byte stream (HDR, LEN, DATA..., CSUM), zero-filled, then released to the core.
`timescale 1ns/1ps

module imem_loader #(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 16,
    parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_FILL,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [7:0]      DEPTH_B = 8'(DEPTH);
    localparam logic [ADDR_W:0] FULL    = (ADDR_W+1)'(DEPTH);

    state_t            state;
    logic [ADDR_W:0]   len;
    logic [7:0]        sum;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W:0]   wc_next;

    // Ready depends on state only; start masks it so a restart never consumes a byte.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            S_HDR, S_LEN, S_DATA, S_CSUM: in_ready = !start;
            default:                      in_ready = 1'b0;
        endcase
    end

    assign accept  = in_valid && in_ready;
    assign wc_next = word_count + 1'b1;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = word_count[ADDR_W-1:0];
        wr_data = '0;
        if (state == S_DATA && accept) begin
            wr_en   = 1'b1;
            wr_data = DATA_W'(in_data);
        end else if (state == S_FILL && !start) begin
            wr_en   = 1'b1;
        end
    end

    // Program store is deliberately not reset; ERR leaves partial images in place.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign fetch_instr = mem[fetch_addr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            len        <= '0;
            sum        <= '0;
            word_count <= '0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else if (start) begin
            state      <= S_HDR;
            sum        <= '0;
            word_count <= '0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_IDLE;
                end
                S_HDR: begin
                    if (accept && in_data == HDR_BYTE) begin
                        state <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        if (in_data != 8'h00 && in_data <= DEPTH_B) begin
                            len   <= in_data[ADDR_W:0];
                            state <= S_DATA;
                        end else begin
                            state    <= S_ERR;
                            load_err <= 1'b1;
                            cpu_hold <= 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        sum        <= sum + in_data;
                        word_count <= wc_next;
                        if (wc_next == len) begin
                            state <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        if (in_data == sum) begin
                            if (len == FULL) begin
                                state     <= S_DONE;
                                load_done <= 1'b1;
                                cpu_hold  <= 1'b0;
                            end else begin
                                state <= S_FILL;
                            end
                        end else begin
                            state    <= S_ERR;
                            load_err <= 1'b1;
                            cpu_hold <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    word_count <= wc_next;
                    if (word_count[ADDR_W-1:0] == '1) begin
                        state     <= S_DONE;
                        load_done <= 1'b1;
                        cpu_hold  <= 1'b0;
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                S_ERR: begin
                    state <= S_ERR;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the CPU's instruction-fetch path: a writable 16 x 8-bit program store plus a framed byte-stream loader.
- Accepts a framed program image over a valid/ready byte interface and writes it into the store.
- Zero-fills unused words, verifies a checksum, then releases the core.
- The core's PC drives fetch_addr and reads fetch_instr; cpu_hold feeds the core's reset while loading.

Parameters:
- ADDR_W, 4, fetch/write address width.
- DATA_W, 8, instruction width ({opcode[7:4], operand[3:0]}).
- DEPTH, 16, number of program words (2**ADDR_W).
- HDR_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  single-cycle pulse; begins, or restarts, a load.
- in_valid  input  1  in_data holds a byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- fetch_addr  input  ADDR_W  instruction fetch address from PC.
- fetch_instr  output  DATA_W  mem[fetch_addr], combinational read.
- cpu_hold  output  1  1 = hold core in reset.
- load_done  output  1  image loaded and checksum verified.
- load_err  output  1  frame rejected.
- word_count  output  ADDR_W+1  words written in current load, 0..16.

Behaviour:
- Byte transfer: occurs at a rising edge with in_valid && in_ready.
- in_ready is decoded from state only; no combinational path from in_valid.
- Sender holds in_data stable until the byte is accepted. Gaps in in_valid are legal anywhere.
- Reset (async, any time): state IDLE, in_ready=0, cpu_hold=1, load_done=0, load_err=0, word_count=0, sum=0.
- Memory array is not reset.
- States: IDLE, HDR, LEN, DATA, CSUM, FILL, DONE, ERR.
- IDLE:
  - in_ready=0.
  - start -> HDR; clears word_count, sum, load_done, load_err; cpu_hold=1.
- HDR:
  - in_ready=1.
  - Accepted byte == HDR_BYTE -> LEN.
  - Any other byte is discarded; stay in HDR (resync hunt).
- LEN:
  - in_ready=1.
  - Accepted byte L with 1 <= L <= 16 -> store L, go to DATA.
  - L == 0 or L > 16 -> ERR.
- DATA:
  - in_ready=1.
  - Each accepted byte b: write mem[word_count[3:0]] <= b; sum <= sum + b (8-bit wrap); word_count++.
  - Go to CSUM on the edge where word_count becomes L.
- CSUM:
  - in_ready=1.
  - Accepted byte == sum -> FILL if L < 16, else DONE.
  - Mismatch -> ERR.
- FILL:
  - in_ready=0.
  - One write per cycle: mem[word_count] <= 8'h00, word_count++.
  - Go to DONE on the edge that writes address 15; FILL lasts 16-L cycles.
- DONE:
  - cpu_hold=0, load_done=1, in_ready=0.
  - Holds until start or reset.
- ERR:
  - cpu_hold=1, load_err=1, in_ready=0.
  - Memory keeps the partially written words.
  - Holds until start or reset.
- start in any state other than IDLE: restart to HDR next edge.
  - Clears word_count, sum, load_done, load_err; sets cpu_hold=1.
  - A byte presented in that cycle is not accepted; in_ready is forced 0 in the start cycle.
- Outputs load_done, load_err, cpu_hold are registered; they change on the edge that enters their state.
- Read/write collision on the same address: fetch_instr shows old data until the write edge, new data after it.
- cpu_hold rises and falls only with clk edges, except during async reset assertion.

Test Plan:
1. Reset, start, stream A5 03 11 22 33 66.
   -> mem[0..2]=11,22,33; mem[3..15]=00 after 13 FILL cycles; then load_done=1, cpu_hold=0; fetch_addr=1 gives 8'h22.
2. Start, stream A5 02 10 20 31 (correct checksum 30).
   -> load_err=1, load_done=0, cpu_hold=1, mem[0]=10, mem[1]=20, word_count=2.
3. Start, stream A5 00; separately A5 11.
   -> ERR on the LEN byte in both cases; no memory writes; word_count=0.
4. Start, stream 00 FF A5 01 7E 7E with random in_valid gaps.
   -> first two bytes discarded; mem[0]=7E, mem[1..15]=00, load_done=1; no byte lost or duplicated.
5. Start, A5 10, bytes 01..10, checksum 88.
   -> DONE directly from CSUM, no FILL cycles; mem[i]=i+1; word_count=16.
6. Assert reset mid-DATA after 2 of 4 bytes, and separately pulse start mid-DATA.
   -> reset: immediate IDLE, in_ready=0, cpu_hold=1.
   -> start: HDR next edge, word_count=0; a following full frame loads correctly.
